cnf_patch_eval: RTL
===================

# cnf_patch_eval

Sequential, table-driven evaluator for ECO patch functions in conjunctive normal form. It holds up to NUM_CLAUSE programmable OR-clauses over NUM_IN patch inputs and computes their AND by scanning one clause per cycle. It reports the first failing clause and uses a start/done handshake. It sits next to the generated combinational patch netlists and lets a candidate patch be loaded and checked at run time without re-synthesis.

## Interface
- NUM_IN, 4, number of patch input literals
- NUM_CLAUSE, 8, clause table depth (≥2)
- CLS_AW, $clog2(NUM_CLAUSE), clause index width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  clause table write strobe
- cfg_addr  in  CLS_AW  clause index to write
- cfg_en  in  1  clause enable bit written with the clause
- cfg_pos  in  NUM_IN  positive-literal mask
- cfg_neg  in  NUM_IN  negative-literal mask
- start  in  1  begin evaluation of in_vec
- in_vec  in  NUM_IN  input assignment, sampled with start
- busy  out  1  evaluation in progress
- done  out  1  one-cycle completion pulse
- result  out  1  CNF value of last evaluation
- fail_idx  out  CLS_AW  lowest failing clause index, 0 if result=1

## Operation
- Clause value c(i) = |(pos_i & x) | |(neg_i & ~x). x is the latched in_vec.
- A disabled clause (en=0) evaluates to 1.
- An enabled clause with pos=neg=0 evaluates to 0.
- result = AND of c(i) over all i. An empty or all-disabled table yields 1.
- The FSM has three states: IDLE, EVAL and DONE.
- IDLE: on start, latch in_vec, set idx=0, set acc=1 and go to EVAL. A write (cfg_we) is accepted only in IDLE.
- EVAL: evaluate clause idx and update acc &= c(idx).
  - On the first c(idx)=0, capture fail_idx=idx.
  - When idx=NUM_CLAUSE-1, go to DONE. Otherwise increment idx.
- DONE: assert done for exactly one cycle, drive result=acc and fail_idx, then go to IDLE.
- result and fail_idx hold until the next DONE.
- start is ignored while busy=1 or in DONE. No queueing.
- cfg_we is ignored while busy=1 or in DONE. The write is dropped and the table is unchanged.
- If start and cfg_we occur in the same IDLE cycle, the write is committed at that edge and the evaluation uses the post-write table.
- Reset (asynchronous, any state):
  - state=IDLE, busy=0, done=0, result=0, fail_idx=0.
  - All clause enable bits are cleared. The pos/neg masks need not be cleared.
- Reset mid-evaluation aborts the evaluation with no done pulse.

## Timing
- Let start be sampled at the edge ending cycle k.
- busy=1 in cycles k+1 through the last EVAL cycle. busy=0 in DONE.
- Clause i is evaluated in cycle k+1+i.
- done=1 in cycle k+NUM_CLAUSE+1. Latency from start to done is NUM_CLAUSE+1 cycles.
- result and fail_idx are valid in the done cycle and afterwards.
- start may be reasserted in the cycle after done, which gives a back-to-back throughput of one evaluation per NUM_CLAUSE+2 cycles.
- The earliest table write after a run is in the first IDLE cycle.

## Configuration
- CNF_EARLY_EXIT_EN defined: EVAL goes to DONE in the cycle a clause fails. done then occurs in cycle k+f+2, where f is the first failing index. Later clauses are not scanned.
- CNF_EARLY_EXIT_EN undefined: every clause is always scanned, giving fixed latency NUM_CLAUSE+1.
- result and fail_idx are identical in both builds.

## Test plan
Common setup for all tests: NUM_IN=4, NUM_CLAUSE=8, x[0]=a, x[1]=b, x[2]=c, x[3]=d. The table holds clause 0 = (a|d), clause 1 = (~b|d), clause 2 = (~c|d), with clauses 3–7 disabled.

- Reset, then start with in_vec=4'b0000 -> done at k+9, result=1, fail_idx=0 (empty table).
- Load the three clauses, start with in_vec=4'b0001 -> result=1, fail_idx=0. Start with in_vec=4'b1110 -> result=1 (d=1 satisfies all clauses).
- Start with in_vec=4'b0011 -> result=0, fail_idx=1.
  - With CNF_EARLY_EXIT_EN: done at k+3.
  - Without CNF_EARLY_EXIT_EN: done at k+9.
- Pulse start and cfg_we during EVAL (cfg_we writes clause 0 = enabled, pos=neg=0) -> only one done pulse. A rerun with in_vec=4'b0001 still gives result=1, because the write was dropped.
- Same-cycle start plus write of an enabled empty clause 5 in IDLE, in_vec=4'b0001 -> result=0, fail_idx=5.
- Assert rst in cycle k+3 of a run -> busy=0 and result=0 immediately, no done pulse. A later start gives result=1, because the enable bits were cleared.

Source files
------------

// File: rtl/cnf_patch_eval.sv
// Sequential CNF evaluator: scans one programmable OR-clause per cycle and ANDs the results.
// Optional build macro CNF_EARLY_EXIT_EN stops the scan at the first failing clause.
module cnf_patch_eval #(
  parameter int NUM_IN     = 4,
  parameter int NUM_CLAUSE = 8,
  parameter int CLS_AW     = $clog2(NUM_CLAUSE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CLS_AW-1:0] cfg_addr,
  input  logic              cfg_en,
  input  logic [NUM_IN-1:0] cfg_pos,
  input  logic [NUM_IN-1:0] cfg_neg,
  input  logic              start,
  input  logic [NUM_IN-1:0] in_vec,
  output logic              busy,
  output logic              done,
  output logic              result,
  output logic [CLS_AW-1:0] fail_idx
);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

  state_t state, state_nxt;

  logic [NUM_CLAUSE-1:0] en_q;
  logic [NUM_IN-1:0]     pos_q [NUM_CLAUSE];
  logic [NUM_IN-1:0]     neg_q [NUM_CLAUSE];
  logic [NUM_IN-1:0]     x_q;
  logic [CLS_AW-1:0]     idx_q;
  logic [CLS_AW-1:0]     fcap_q;
  logic                  acc_q;
  logic                  cls_val;
  logic                  last_cls;
  logic                  cfg_wr;

  // A disabled clause is forced true; an enabled clause with empty masks is false.
  assign cls_val  = ~en_q[idx_q] | (|(pos_q[idx_q] & x_q)) | (|(neg_q[idx_q] & ~x_q));
  assign last_cls = (idx_q == CLS_AW'(NUM_CLAUSE - 1));
  assign cfg_wr   = cfg_we && (state == S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_EVAL;
      S_EVAL: begin
`ifdef CNF_EARLY_EXIT_EN
        if (last_cls || !cls_val) state_nxt = S_DONE;
`else
        if (last_cls) state_nxt = S_DONE;
`endif
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      S_EVAL:  busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= '0;
      idx_q    <= '0;
      fcap_q   <= '0;
      acc_q    <= 1'b1;
      result   <= 1'b0;
      fail_idx <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        x_q    <= in_vec;
        idx_q  <= '0;
        fcap_q <= '0;
        acc_q  <= 1'b1;
      end else if (state == S_EVAL) begin
        acc_q <= acc_q & cls_val;
        if (acc_q && !cls_val) fcap_q <= idx_q;
        if (!last_cls) idx_q <= idx_q + 1'b1;
        // Results are published on entry to DONE and then held until the next run completes.
        if (state_nxt == S_DONE) begin
          result   <= acc_q & cls_val;
          fail_idx <= (acc_q && !cls_val) ? idx_q : fcap_q;
        end
      end
    end
  end

  // Only the enable bits need a defined reset value; a disabled clause ignores its masks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         en_q           <= '0;
    else if (cfg_wr) en_q[cfg_addr] <= cfg_en;
  end

  // NOTE: the mask table has no reset so it can map onto plain storage without a reset network.
  always_ff @(posedge clk) begin
    if (cfg_wr) begin
      pos_q[cfg_addr] <= cfg_pos;
      neg_q[cfg_addr] <= cfg_neg;
    end
  end

endmodule
